// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB3 command initiator.
// The response struct holds read data at the widest supported data width.
package apb_master_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } state_e;

    localparam int unsigned DefaultTimeout = 255;
    localparam int unsigned MaxDataWidth   = 64;

    typedef struct packed {
        logic [MaxDataWidth-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired_o flags when the count reaches TIMEOUT.
// With TIMEOUT = 0 the timer never expires.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CntWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TIMEOUT);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != TimeoutVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == TimeoutVal);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-beat command/response to APB3 initiator with wait-state timeout.
// All outputs are registered and follow the next state of the FSM.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = DefaultTimeout
) (
    input  logic                  PCLK,
    input  logic                  PRESERN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  rsp_valid_q, rsp_valid_d;
    rsp_t                  rsp_q, rsp_d;
    logic                  timer_expired;

    // Counter is cleared during SETUP so it starts at zero on entry to ACCESS.
    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk_i      (PCLK),
        .rst_ni     (PRESERN),
        .clear_i    (state_q == StSetup),
        .count_en_i ((state_q == StAccess) && !PREADY),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rsp_d    = rsp_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = StSetup;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                // Completion takes priority over a coincident timeout.
                if (PREADY) begin
                    state_d       = StResp;
                    rsp_d.rdata   = pwrite_q ? '0 : MaxDataWidth'(PRDATA);
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                end else if (timer_expired) begin
                    state_d       = StResp;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        psel_d      = (state_d == StSetup) || (state_d == StAccess);
        penable_d   = (state_d == StAccess);
        rsp_valid_d = (state_d == StResp);
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Fabric-side APB3 initiator that turns single-beat commands from fabric logic (sequencers, self-test engines) into APB3 transfers toward an APB3 responder such as the m_control motor-control slave. It drives the APB3 initiator signals directly, handles wait states, and aborts stalled transfers with a timeout. Each accepted command produces exactly one response carrying read data and error status. It sits in place of, or alongside through an arbiter, the MSS master port on the CoreAPB3 bus.

## Interface
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA and command/response data width.
- TIMEOUT, 255, max ACCESS cycles with PREADY low before abort; 0 disables the timeout.
- PCLK  in  1  bus clock; all logic on the rising edge.
- PRESERN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR was sampled, or the transfer timed out.
- rsp_timeout  out  1  transfer aborted by the timeout.
- busy  out  1  state is not IDLE.
- PSEL, PENABLE, PWRITE  out  1 each  APB3 initiator controls.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH.
- PREADY, PSLVERR  in  1 each; PRDATA  in  DATA_WIDTH.

## Operation
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, go to SETUP.
  - SETUP: one cycle. Go to ACCESS.
  - ACCESS: wait for PREADY or timeout. Go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Capture at accept:
  - cmd_addr → PADDR, cmd_write → PWRITE.
  - cmd_wdata → PWDATA for writes; PWDATA = 0 for reads.
  - These outputs stay constant through SETUP and ACCESS.
- PSEL=1 in SETUP and ACCESS; PENABLE=1 only in ACCESS.
- Normal completion is the first ACCESS cycle with PREADY=1:
  - Reads: PRDATA → rsp_rdata. Writes: rsp_rdata=0.
  - PSLVERR → rsp_err. rsp_timeout=0.
- Timeout, when TIMEOUT>0:
  - The wait counter is cleared on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT and PREADY is still 0, leave ACCESS with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 in that same cycle, completion wins and no timeout is reported.
- Response fields stay stable while rsp_valid=1 && rsp_ready=0.
- Only one transfer is outstanding at a time; no new command is accepted until the response handshake completes.
- Counter width is $clog2(TIMEOUT+1), minimum 1; the counter saturates and never wraps.

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid, rsp_err, rsp_timeout, busy = 0; rsp_rdata = 0.
  - cmd_ready = 0 during reset, 1 from the first edge after PRESERN deasserts.
- All outputs are registered.
- Zero-wait-state example, with the command accepted at edge N:
  - After edge N: PSEL=1, cmd_ready=0.
  - After N+1: PENABLE=1.
  - Edge N+2 samples PREADY=1; after N+2: PSEL=0, PENABLE=0, rsp_valid=1.
  - If rsp_ready=1 at edge N+3, cmd_ready=1 after N+3.
- Each wait cycle adds one cycle of latency.
- With rsp_ready tied high, back-to-back commands run at one transfer per 4 cycles.
- If PRESERN asserts mid-transfer, PSEL/PENABLE drop immediately (asynchronously), the transfer is dropped, and no response is issued.

## Structure
- Package apb_master_pkg contains:
  - the state enum (IDLE, SETUP, ACCESS, RESP), 2 bits;
  - the default TIMEOUT constant;
  - a response struct (rdata, err, timeout).
- One sub-module, apb_wait_timer:
  - inputs: clear, count-enable;
  - output: expired (counter == TIMEOUT);
  - parameter: TIMEOUT; expired is held at 0 when TIMEOUT=0.
- The FSM, capture registers and response registers live in apb_cmd_master.

## Test plan
- Write, zero wait: addr 0x0000_0004, data 0x0000_00C8, PREADY=1 → PSEL 2 cycles, PENABLE 1 cycle, PWRITE=1, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: PRDATA=0xDEAD_BEEF presented with PREADY → rsp_rdata=0xDEAD_BEEF, PENABLE high 4 cycles, PADDR stable throughout.
- Error and backpressure: PSLVERR=1 with PREADY; rsp_ready held low 5 cycles → rsp_err=1 and response stable; cmd_ready stays 0 until the handshake completes.
- Timeouts, TIMEOUT=4:
  - PREADY never rises → abort after 4 wait cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY rises on the 4th wait cycle → normal completion, rsp_timeout=0.
- Reset mid-ACCESS: PRESERN low while PENABLE=1 → all outputs return to reset values without waiting for a clock edge, no rsp_valid; the next command after release completes normally.
